wb_qos_arbiter: RTL and testbench



---
 rtl/wb_pkg.sv | 14 +
 rtl/wb_timeout_wdt.sv | 39 +++
 rtl/wb_qos_arbiter.sv | 141 ++++++++++++++
 tb/tb_wb_qos_arbiter.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared Wishbone arbitration types and grant encodings.
package wb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_e;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_M0   = 2'b01;
  localparam logic [1:0] GNT_M1   = 2'b10;

endpackage

// File: rtl/wb_timeout_wdt.sv
// Bus watchdog: counts un-acked strobe cycles, fires at terminal count.
module wb_timeout_wdt #(
  parameter int TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_i,
  input  logic stb_i,
  input  logic ack_i,
  output logic fire_o
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TERM = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CMAX = CW'(TIMEOUT);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (start_i || ack_i) begin
      cnt_d = '0;
    end else if (stb_i && (cnt_q != CMAX)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A same-cycle ack always beats the terminal count.
  assign fire_o = (TIMEOUT != 0) && stb_i && !ack_i && (cnt_q == TERM);

endmodule

// File: rtl/wb_qos_arbiter.sv
// Two-master Wishbone arbiter: data master first, bounded fetch starvation,
// and a watchdog that turns a missing slave ack into an err to the owner.
module wb_qos_arbiter
  import wb_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int SELECT_WIDTH = 4,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [ADDR_WIDTH-1:0]   wbm0_adr_i,
  input  logic [DATA_WIDTH-1:0]   wbm0_dat_i,
  input  logic [SELECT_WIDTH-1:0] wbm0_sel_i,
  input  logic                    wbm0_we_i,
  input  logic                    wbm0_cyc_i,
  input  logic                    wbm0_stb_i,
  output logic [DATA_WIDTH-1:0]   wbm0_dat_o,
  output logic                    wbm0_ack_o,
  output logic                    wbm0_err_o,
  input  logic [ADDR_WIDTH-1:0]   wbm1_adr_i,
  input  logic [DATA_WIDTH-1:0]   wbm1_dat_i,
  input  logic [SELECT_WIDTH-1:0] wbm1_sel_i,
  input  logic                    wbm1_we_i,
  input  logic                    wbm1_cyc_i,
  input  logic                    wbm1_stb_i,
  output logic [DATA_WIDTH-1:0]   wbm1_dat_o,
  output logic                    wbm1_ack_o,
  output logic                    wbm1_err_o,
  output logic [ADDR_WIDTH-1:0]   wbs_adr_o,
  output logic [DATA_WIDTH-1:0]   wbs_dat_o,
  output logic [SELECT_WIDTH-1:0] wbs_sel_o,
  output logic                    wbs_we_o,
  output logic                    wbs_cyc_o,
  output logic                    wbs_stb_o,
  input  logic [DATA_WIDTH-1:0]   wbs_dat_i,
  input  logic                    wbs_ack_i,
  input  logic                    wbs_err_i,
  output logic [1:0]              grant_o,
  output logic                    timeout_o
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] SLIM = SW'(STARVE_LIMIT);

  arb_state_e    state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          req0, req1, fire, start;

  assign req0  = wbm0_cyc_i & wbm0_stb_i;
  assign req1  = wbm1_cyc_i & wbm1_stb_i;
  assign start = (state_q == IDLE) && (state_d != IDLE);

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    unique case (state_q)
      IDLE: begin
        if (req1 && (!req0 || (starve_q < SLIM))) begin
          state_d  = GNT1;
          starve_d = req0 ? starve_q + SW'(1) : '0;
        end else if (req0) begin
          state_d  = GNT0;
          starve_d = '0;
        end else begin
          starve_d = '0;
        end
      end
      GNT0: if (!wbm0_cyc_i || fire) state_d = IDLE;
      GNT1: if (!wbm1_cyc_i || fire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  wb_timeout_wdt #(
    .TIMEOUT(TIMEOUT)
  ) u_wdt (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .start_i(start),
    .stb_i  (wbs_stb_o),
    .ack_i  (wbs_ack_i),
    .fire_o (fire)
  );

  assign wbm0_dat_o = wbs_dat_i;
  assign wbm1_dat_o = wbs_dat_i;
  assign timeout_o  = fire;

  always_comb begin
    wbs_adr_o  = '0;
    wbs_dat_o  = '0;
    wbs_sel_o  = '0;
    wbs_we_o   = 1'b0;
    wbs_cyc_o  = 1'b0;
    wbs_stb_o  = 1'b0;
    wbm0_ack_o = 1'b0;
    wbm0_err_o = 1'b0;
    wbm1_ack_o = 1'b0;
    wbm1_err_o = 1'b0;
    grant_o    = GNT_NONE;
    unique case (state_q)
      GNT0: begin
        wbs_adr_o  = wbm0_adr_i;
        wbs_dat_o  = wbm0_dat_i;
        wbs_sel_o  = wbm0_sel_i;
        wbs_we_o   = wbm0_we_i;
        wbs_cyc_o  = wbm0_cyc_i;
        wbs_stb_o  = wbm0_stb_i;
        wbm0_ack_o = wbs_ack_i;
        wbm0_err_o = wbs_err_i | fire;
        grant_o    = GNT_M0;
      end
      GNT1: begin
        wbs_adr_o  = wbm1_adr_i;
        wbs_dat_o  = wbm1_dat_i;
        wbs_sel_o  = wbm1_sel_i;
        wbs_we_o   = wbm1_we_i;
        wbs_cyc_o  = wbm1_cyc_i;
        wbs_stb_o  = wbm1_stb_i;
        wbm1_ack_o = wbs_ack_i;
        wbm1_err_o = wbs_err_i | fire;
        grant_o    = GNT_M1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wb_qos_arbiter.sv
// Bench for wb_qos_arbiter: cycle model plus directed arbitration scenarios.
module tb_wb_qos_arbiter;

  localparam int TO  = 8;
  localparam int LIM = 4;

  logic clk = 1'b0;
  logic rst_i;

  logic [31:0] m_adr [2];
  logic [31:0] m_dat [2];
  logic [3:0]  m_sel [2];
  logic        m_we  [2];
  logic        m_cyc [2];
  logic        m_stb [2];

  logic [31:0] d0, d1;
  logic        a0, e0, a1, e1;
  logic [31:0] s_adr, s_dat;
  logic [3:0]  s_sel;
  logic        s_we, s_cyc, s_stb;
  logic [31:0] slv_data;
  logic        wbs_ack_i = 1'b0;
  logic        wbs_err_i = 1'b0;
  logic [1:0]  grant;
  logic        tmo;

  wb_qos_arbiter #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .SELECT_WIDTH(4),
    .STARVE_LIMIT(LIM), .TIMEOUT(TO)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .wbm0_adr_i(m_adr[0]), .wbm0_dat_i(m_dat[0]), .wbm0_sel_i(m_sel[0]),
    .wbm0_we_i(m_we[0]), .wbm0_cyc_i(m_cyc[0]), .wbm0_stb_i(m_stb[0]),
    .wbm0_dat_o(d0), .wbm0_ack_o(a0), .wbm0_err_o(e0),
    .wbm1_adr_i(m_adr[1]), .wbm1_dat_i(m_dat[1]), .wbm1_sel_i(m_sel[1]),
    .wbm1_we_i(m_we[1]), .wbm1_cyc_i(m_cyc[1]), .wbm1_stb_i(m_stb[1]),
    .wbm1_dat_o(d1), .wbm1_ack_o(a1), .wbm1_err_o(e1),
    .wbs_adr_o(s_adr), .wbs_dat_o(s_dat), .wbs_sel_o(s_sel),
    .wbs_we_o(s_we), .wbs_cyc_o(s_cyc), .wbs_stb_o(s_stb),
    .wbs_dat_i(slv_data), .wbs_ack_i(wbs_ack_i), .wbs_err_i(wbs_err_i),
    .grant_o(grant), .timeout_o(tmo)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Slave: acks the slat-th strobe cycle after the first (slat<0: never).
  int   slat = -1;
  int   wcnt = 0;
  logic force_ack = 1'b0;
  logic last_stb = 1'b0, last_ack = 1'b0;

  always @(negedge clk) begin
    last_stb = s_stb;
    last_ack = wbs_ack_i;
  end

  always @(posedge clk) begin
    #2;
    wcnt = (last_ack || !last_stb) ? 0 : wcnt + 1;
    wbs_ack_i = force_ack || (s_stb && slat >= 0 && wcnt == slat);
  end

  // Reference model: owner, starvation count, strobe cycles since grant/ack.
  logic started = 1'b0;
  int   m_own = 0;
  int   m_st = 0;
  int   m_to = 0;

  always @(posedge clk) begin
    int  o;
    logic r0, r1, f;
    r0 = m_cyc[0] & m_stb[0];
    r1 = m_cyc[1] & m_stb[1];
    if (rst_i) begin
      started = 1'b1;
      m_own = 0; m_st = 0; m_to = 0;
    end else if (started) begin
      if (m_own == 0) begin
        if (r1 && (!r0 || m_st < LIM)) begin
          m_own = 2; m_to = 0;
          m_st = r0 ? m_st + 1 : 0;
        end else if (r0) begin
          m_own = 1; m_to = 0; m_st = 0;
        end else begin
          m_st = 0;
        end
      end else begin
        o = m_own - 1;
        f = m_stb[o] && !wbs_ack_i && (m_to == TO - 1);
        if (wbs_ack_i) m_to = 0;
        else if (m_stb[o] && m_to < TO) m_to++;
        if (!m_cyc[o] || f) m_own = 0;
      end
    end
  end

  always @(negedge clk) begin
    int o;
    logic [31:0] ea, ed; logic [3:0] es;
    logic ew, ec, est, f;
    logic [1:0] eg, eack, eerr;
    if (started) begin
      ea = 0; ed = 0; es = 0; ew = 0; ec = 0; est = 0; f = 0;
      eg = 2'b00; eack = 2'b00; eerr = 2'b00;
      if (m_own != 0) begin
        o = m_own - 1;
        ea = m_adr[o]; ed = m_dat[o]; es = m_sel[o];
        ew = m_we[o]; ec = m_cyc[o]; est = m_stb[o];
        eg = 2'(1 << o);
        f = m_stb[o] && !wbs_ack_i && (m_to == TO - 1);
        eack[o] = wbs_ack_i;
        eerr[o] = wbs_err_i | f;
      end
      chk("grant", grant, eg);
      chk("wbs_adr", s_adr, ea);
      chk("wbs_dat", s_dat, ed);
      chk("wbs_sel", s_sel, es);
      chk("wbs_we", s_we, ew);
      chk("wbs_cyc", s_cyc, ec);
      chk("wbs_stb", s_stb, est);
      chk("ack0", a0, eack[0]);
      chk("ack1", a1, eack[1]);
      chk("err0", e0, eerr[0]);
      chk("err1", e1, eerr[1]);
      chk("timeout", tmo, f);
      chk("dat0", d0, slv_data);
      chk("dat1", d1, slv_data);
    end
  end

  // Event recorder for the literal checks.
  int         cyc_n = 0;
  logic [1:0] prev_g = 2'b00;
  logic [1:0] gseq[$];
  int         gcyc[$];
  int         tcnt = 0, a0cnt = 0, a1cnt = 0;

  always @(posedge clk) cyc_n++;

  always @(negedge clk) begin
    if (grant != 2'b00 && prev_g == 2'b00) begin
      gseq.push_back(grant);
      gcyc.push_back(cyc_n);
    end
    prev_g = grant;
    if (tmo) tcnt++;
    if (a0) a0cnt++;
    if (a1) a1cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m(input int m, input logic [31:0] adr, input logic we,
                       input logic [31:0] wd);
    m_adr[m] = adr; m_dat[m] = wd; m_we[m] = we; m_sel[m] = 4'hF;
    m_cyc[m] = 1'b1; m_stb[m] = 1'b1;
  endtask

  task automatic drop(input int m);
    m_cyc[m] = 1'b0; m_stb[m] = 1'b0; m_we[m] = 1'b0;
    m_adr[m] = '0; m_dat[m] = '0; m_sel[m] = '0;
  endtask

  task automatic run_m(input int m, input logic [31:0] adr, input logic we,
                       input logic [31:0] wd, input int budget,
                       output logic ga, output logic ge, output logic [31:0] rd,
                       output int n, output int first);
    logic [1:0] code;
    int k;
    code = (m == 0) ? 2'b01 : 2'b10;
    set_m(m, adr, we, wd);
    ga = 0; ge = 0; rd = '0; n = 0; first = 0; k = 0;
    while (!ga && !ge && k < budget) begin
      @(negedge clk);
      k++;
      if (grant == code) begin
        if (first == 0) first = k;
        if (s_stb) n++;
        ga = (m == 0) ? a0 : a1;
        ge = (m == 0) ? e0 : e1;
        if (ga) rd = (m == 0) ? d0 : d1;
      end
    end
    chk($sformatf("m%0d_done", m), ga | ge, 1'b1);
  endtask

  initial begin
    #60000;
    $display("FAIL global_time_limit: got expired, expected finish");
    $fatal(1);
  end

  initial begin
    logic ga, ge, gb, gf;
    logic [31:0] rd, rd2;
    int n, first, n2, first2, dc1;
    rst_i = 1'b1;
    slv_data = '0;
    drop(0);
    drop(1);
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    chk("rst_grant", grant, 2'b00);
    chk("rst_cyc", s_cyc, 1'b0);
    chk("rst_timeout", tmo, 1'b0);
    chk("rst_ack0", a0, 1'b0);
    step();

    // Solo fetch read with a two-cycle slave.
    slv_data = 32'hDEADBEEF;
    slat = 2;
    a0cnt = 0;
    run_m(0, 32'h8000_0000, 1'b0, '0, 20, ga, ge, rd, n, first);
    chk("solo_first_grant", first, 2);
    chk("solo_stb_cycles", n, 3);
    chk("solo_ack", ga, 1'b1);
    chk("solo_err", ge, 1'b0);
    chk("solo_rdata", rd, 32'hDEADBEEF);
    step();
    drop(0);
    repeat (3) step();
    chk("solo_ack_pulses", a0cnt, 1);

    // Same-cycle contention.
    slat = 1;
    slv_data = 32'h1234_5678;
    gseq.delete();
    gcyc.delete();
    dc1 = 0;
    fork
      begin
        run_m(0, 32'h0000_0100, 1'b0, '0, 40, ga, ge, rd, n, first);
        step();
        drop(0);
      end
      begin
        run_m(1, 32'h0000_0200, 1'b1, 32'hCAFE_F00D, 40, gb, gf, rd2, n2, first2);
        step();
        drop(1);
        dc1 = cyc_n;
      end
    join
    repeat (3) step();
    chk("cont_grants", gseq.size(), 2);
    if (gseq.size() == 2) begin
      chk("cont_first_owner", gseq[0], 2'b10);
      chk("cont_second_owner", gseq[1], 2'b01);
      chk("cont_switch_gap", gcyc[1] - dc1, 2);
    end

    // Starvation bound: six M1 singles against a waiting M0.
    slat = 0;
    gseq.delete();
    gcyc.delete();
    fork
      begin
        run_m(0, 32'h0000_0300, 1'b0, '0, 80, ga, ge, rd, n, first);
        step();
        drop(0);
      end
      begin
        for (int i = 0; i < 6; i++) begin
          run_m(1, 32'h0000_0400 + 32'(i), 1'b1, 32'(i), 80, gb, gf, rd2, n2, first2);
          step();
          drop(1);
          step();
        end
      end
    join
    repeat (3) step();
    chk("starve_grants", gseq.size(), 7);
    if (gseq.size() >= 6) begin
      chk("starve_seq", {gseq[0], gseq[1], gseq[2], gseq[3], gseq[4], gseq[5]},
          12'b10_10_10_10_01_10);
    end

    // Watchdog: slave never acks; M1 lingers one cycle after err.
    slat = -1;
    tcnt = 0;
    a1cnt = 0;
    run_m(1, 32'h0000_0500, 1'b0, '0, 30, ga, ge, rd, n, first);
    chk("to_err", ge, 1'b1);
    chk("to_ack", ga, 1'b0);
    chk("to_stb_cycles", n, 8);
    step();
    @(negedge clk);
    chk("to_cyc_after", s_cyc, 1'b0);
    chk("to_grant_after", grant, 2'b00);
    step();
    drop(1);
    repeat (4) step();
    chk("to_pulses", tcnt, 1);
    chk("to_no_ack", a1cnt, 0);

    // Ack exactly on the terminal count.
    slat = 7;
    tcnt = 0;
    run_m(1, 32'h0000_0600, 1'b0, '0, 30, ga, ge, rd, n, first);
    chk("tc_ack", ga, 1'b1);
    chk("tc_err", ge, 1'b0);
    chk("tc_stb_cycles", n, 8);
    step();
    drop(1);
    repeat (3) step();
    chk("tc_no_timeout", tcnt, 0);

    // Abort: M0 drops cyc without an ack.
    slat = -1;
    set_m(0, 32'h0000_0700, 1'b0, '0);
    repeat (3) step();
    @(negedge clk);
    chk("abort_granted", grant, 2'b01);
    step();
    drop(0);
    @(negedge clk);
    chk("abort_drop_cycle", grant, 2'b01);
    step();
    @(negedge clk);
    chk("abort_idle", grant, 2'b00);
    step();

    // Reset while GNT0 waits; a late ack must not reach M0.
    set_m(0, 32'h0000_0800, 1'b0, '0);
    repeat (3) step();
    rst_i = 1'b1;
    @(negedge clk);
    chk("rst_mid_granted", grant, 2'b01);
    step();
    rst_i = 1'b0;
    drop(0);
    force_ack = 1'b1;
    @(negedge clk);
    chk("rst_mid_grant", grant, 2'b00);
    chk("rst_mid_cyc", s_cyc, 1'b0);
    chk("rst_mid_late_ack", a0, 1'b0);
    step();
    force_ack = 1'b0;
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
